// File: rtl/byte_to_updn.sv
// rtl/byte_to_updn.sv - channel stepper driving momentary up/dn switch pulses
//
// Steps a tracked channel value (cur) towards a requested target by emitting
// timed pulses on up or dn. Each step is one CHECK cycle, PULSE_W cycles of
// pulse and GAP_W cycles of gap. With ALTEN=1 only up pulses are used and cur
// wraps from COUNTMAX to COUNTMIN; with ALTEN=0 up/dn move towards the target
// and saturate at the limits.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   one-cycle start strobe, target sampled with it
//   target in   requested channel [7:0]
//   sync   in   in IDLE, forces cur to SWDEF without pulsing
//   up     out  up-switch drive, active high
//   dn     out  down-switch drive, active high
//   cur    out  tracked current channel [7:0]
//   busy   out  high while a request is being processed
//   done   out  one-cycle pulse when the target is reached
//   err    out  one-cycle pulse when a req is rejected
module byte_to_updn #(
  parameter int COUNTMAX = 4,
  parameter int COUNTMIN = 0,
  parameter int SWDEF    = 0,
  parameter int ALTEN    = 1,
  parameter int PULSE_W  = 2,
  parameter int GAP_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] target,
  input  logic       sync,
  output logic       up,
  output logic       dn,
  output logic [7:0] cur,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0]  CMAX      = 8'(COUNTMAX);
  localparam logic [7:0]  CMIN      = 8'(COUNTMIN);
  localparam logic [7:0]  HOME      = 8'(SWDEF);
  localparam logic [7:0]  SPAN      = CMAX - CMIN;
  localparam logic [15:0] PULSE_RLD = 16'(PULSE_W - 1);
  localparam logic [15:0] GAP_RLD   = 16'(GAP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  tgt_q, tgt_d;
  logic [7:0]  cur_q, cur_d;
  logic        dir_up_q, dir_up_d;
  logic        up_q, up_d;
  logic        dn_q, dn_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [7:0] tgt_off;
  logic       in_range;
  logic [7:0] cur_up;
  logic [7:0] cur_dn;

  // Offset from COUNTMIN wraps to a large value when target < COUNTMIN, so a
  // single unsigned compare covers both bounds.
  assign tgt_off  = target - CMIN;
  assign in_range = (tgt_off <= SPAN);

  assign cur_up = (cur_q >= CMAX) ? ((ALTEN != 0) ? CMIN : CMAX) : cur_q + 8'd1;
  assign cur_dn = (cur_q <= CMIN) ? cur_q : cur_q - 8'd1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    tgt_d    = tgt_q;
    cur_d    = cur_q;
    dir_up_d = dir_up_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sync) begin
          cur_d = HOME;
        end
        if (req) begin
          if (in_range) begin
            tgt_d   = target;
            timer_d = 16'd0;
            state_d = S_CHECK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        timer_d = 16'd0;
        if (cur_q == tgt_q) begin
          state_d = S_DONE;
        end else begin
          dir_up_d = (ALTEN != 0) || (tgt_q > cur_q);
          timer_d  = PULSE_RLD;
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (timer_q == 16'd0) begin
          // cur changes on the same edge that drops the pulse
          cur_d   = dir_up_q ? cur_up : cur_dn;
          timer_d = GAP_RLD;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_GAP: begin
        if (timer_q == 16'd0) begin
          state_d = S_CHECK;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DONE: begin
        timer_d = 16'd0;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = 16'd0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    up_d   = (state_d == S_PULSE) && dir_up_d;
    dn_d   = (state_d == S_PULSE) && !dir_up_d;
    busy_d = (state_d == S_CHECK) || (state_d == S_PULSE) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= 16'd0;
      tgt_q    <= HOME;
      cur_q    <= HOME;
      dir_up_q <= 1'b1;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      dir_up_q <= dir_up_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign up   = up_q;
  assign dn   = dn_q;
  assign cur  = cur_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_byte_to_updn.sv
// tb/tb_byte_to_updn.sv - self-checking bench for byte_to_updn (ALTEN=1 and ALTEN=0)
module tb_byte_to_updn;

  localparam int P     = 2;
  localparam int G     = 3;
  localparam int S     = 1 + P + G;
  localparam int CMAX  = 4;
  localparam int CMIN  = 0;
  localparam int SWDEF = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       sync;
  logic [7:0] target;
  logic [1:0] up, dn, busy, done, err;
  logic [7:0] cur0, cur1;

  int checks = 0;
  int errors = 0;
  int mcur[2];

  always #5 clk = ~clk;

  byte_to_updn #(.COUNTMAX(CMAX), .COUNTMIN(CMIN), .SWDEF(SWDEF), .ALTEN(1),
                 .PULSE_W(P), .GAP_W(G)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req(req), .target(target), .sync(sync),
    .up(up[0]), .dn(dn[0]), .cur(cur0), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  byte_to_updn #(.COUNTMAX(CMAX), .COUNTMIN(CMIN), .SWDEF(SWDEF), .ALTEN(0),
                 .PULSE_W(P), .GAP_W(G)) u_lim (
    .clk(clk), .rst_n(rst_n), .req(req), .target(target), .sync(sync),
    .up(up[1]), .dn(dn[1]), .cur(cur1), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int next_cur(int c, bit wrap, int t);
    if (wrap || t > c) return (c >= CMAX) ? (wrap ? CMIN : CMAX) : c + 1;
    return (c <= CMIN) ? c : c - 1;
  endfunction

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s i%0d cur", tag, i), (i == 0) ? cur0 : cur1, 8'(mcur[i]));
      chk($sformatf("%s i%0d up", tag, i), 8'(up[i]), 8'd0);
      chk($sformatf("%s i%0d dn", tag, i), 8'(dn[i]), 8'd0);
      chk($sformatf("%s i%0d busy", tag, i), 8'(busy[i]), 8'd0);
      chk($sformatf("%s i%0d done", tag, i), 8'(done[i]), 8'd0);
      chk($sformatf("%s i%0d err", tag, i), 8'(err[i]), 8'd0);
    end
  endtask

  // Issue one req and check every cycle of both instances against a waveform
  // derived from the list of channel values each instance must pass through.
  // inj>=0 fires a second req mid-transaction; rst_at>0 resets in that cycle.
  task automatic do_req(input int tgt, input int inj, input bit with_sync, input int rst_at);
    int  seq[2][$];
    int  d[2];
    int  c0[2];
    int  last;
    bit  valid;
    valid = (tgt >= CMIN) && (tgt <= CMAX);
    for (int i = 0; i < 2; i++) begin
      c0[i] = with_sync ? SWDEF : mcur[i];
      seq[i].delete();
      seq[i].push_back(c0[i]);
      if (valid)
        while (seq[i][$] != tgt && seq[i].size() < 300)
          seq[i].push_back(next_cur(seq[i][$], i == 0, tgt));
      d[i] = valid ? (seq[i].size() - 1) * S + 2 : 1;
    end
    last = ((d[0] > d[1]) ? d[0] : d[1]) + 1;
    if (rst_at > 0) last = rst_at;

    @(posedge clk); #1;
    req = 1'b1; target = 8'(tgt); sync = with_sync;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin req = 1'b0; sync = 1'b0; end
      if (inj >= 0 && c == 3) begin req = 1'b1; target = 8'(inj); end
      if (inj >= 0 && c == 4) req = 1'b0;
      for (int i = 0; i < 2; i++) begin
        int ecur, k, r;
        bit eup, edn, ebusy, edone, eerr, pulse, dirup;
        ecur = tgt; eup = 0; edn = 0; ebusy = 0; edone = 0; eerr = 0;
        if (!valid) begin
          ecur = c0[i];
          eerr = (c == 1);
        end else if (c == d[i]) begin
          edone = 1;
        end else if (c < d[i]) begin
          ebusy = 1;
          k = (c - 1) / S;
          r = (c - 1) % S;
          ecur  = (r <= P) ? seq[i][k] : seq[i][k + 1];
          pulse = (r >= 1) && (r <= P);
          dirup = (i == 0) || (tgt > seq[i][k]);
          eup   = pulse && dirup;
          edn   = pulse && !dirup;
        end
        chk($sformatf("t%0d c%0d i%0d cur", tgt, c, i), (i == 0) ? cur0 : cur1, 8'(ecur));
        chk($sformatf("t%0d c%0d i%0d up", tgt, c, i), 8'(up[i]), 8'(eup));
        chk($sformatf("t%0d c%0d i%0d dn", tgt, c, i), 8'(dn[i]), 8'(edn));
        chk($sformatf("t%0d c%0d i%0d busy", tgt, c, i), 8'(busy[i]), 8'(ebusy));
        chk($sformatf("t%0d c%0d i%0d done", tgt, c, i), 8'(done[i]), 8'(edone));
        chk($sformatf("t%0d c%0d i%0d err", tgt, c, i), 8'(err[i]), 8'(eerr));
      end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        mcur[0] = SWDEF;
        mcur[1] = SWDEF;
        check_idle("midreset");
        #1 rst_n = 1'b1;
        return;
      end
    end
    for (int i = 0; i < 2; i++) mcur[i] = valid ? tgt : c0[i];
  endtask

  task automatic do_sync();
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
    mcur[0] = SWDEF;
    mcur[1] = SWDEF;
    check_idle("sync");
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; sync = 1'b0; target = 8'd0;
    mcur[0] = SWDEF; mcur[1] = SWDEF;
    #12;
    check_idle("reset");
    @(negedge clk); rst_n = 1'b1;

    do_req(3, 1, 1'b0, 0);    // 0->3 in up steps, injected req ignored
    do_req(4, -1, 1'b0, 0);   // 3->4
    do_req(1, -1, 1'b0, 0);   // wrap 4->0->1 / limited dn 4->3->2->1
    do_req(4, -1, 1'b0, 0);
    do_req(2, -1, 1'b0, 0);   // limited: 4->3->2 on dn
    do_req(2, -1, 1'b0, 0);   // zero-step
    do_req(4, -1, 1'b0, 0);
    do_req(4, -1, 1'b0, 0);   // at upper limit, zero-step
    do_req(7, -1, 1'b0, 0);   // out of range
    do_req(255, -1, 1'b0, 0);
    do_req(3, -1, 1'b0, 0);
    do_sync();                // cur 3 -> 0 without pulses
    do_req(3, -1, 1'b0, 3);   // reset in 2nd high cycle of first pulse
    do_req(1, -1, 1'b0, 0);
    do_req(2, -1, 1'b1, 0);   // sync and req together
    repeat (14) do_req(int'($urandom_range(0, 6)), -1, ($urandom_range(0, 3) == 0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_to_updn.md
BYTE_TO_UPDN -- requirements
Module: byte_to_updn

Interface
REQ-001 Parameter COUNTMAX, default 4: highest valid channel value, range 0..255.
REQ-002 Parameter COUNTMIN, default 0: lowest valid channel value, range 0..COUNTMAX.
REQ-003 Parameter SWDEF, default 0: power-on/home channel value, range COUNTMIN..COUNTMAX.
REQ-004 Parameter ALTEN, default 1: 1 = up-only with wrap, 0 = limited up/down.
REQ-005 Parameter PULSE_W, default 2: width of the up/dn high time in clk cycles, range 1..65535.
REQ-006 Parameter GAP_W, default 3: low time after each pulse in clk cycles, range 1..65535.
REQ-007 clk  input  1  system clock; all logic is rising-edge.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 req  input  1  one-cycle start strobe; target is sampled with it.
REQ-010 target  input  8  requested channel.
REQ-011 sync  input  1  when idle, forces the tracked channel to SWDEF without pulsing.
REQ-012 up  output  1  momentary up-switch drive, active high.
REQ-013 dn  output  1  momentary down-switch drive, active high.
REQ-014 cur  output  8  tracked current channel of the driven device.
REQ-015 busy  output  1  high from the cycle after an accepted req until the DONE state.
REQ-016 done  output  1  one-cycle pulse when the target is reached.
REQ-017 err  output  1  one-cycle pulse when a req is rejected.

Function
REQ-018 States SHALL be IDLE, CHECK, PULSE, GAP and DONE; all outputs SHALL be registered.
REQ-019 In IDLE, req with COUNTMIN<=target<=COUNTMAX SHALL latch target and go to CHECK, with busy=1 from the next cycle.
REQ-020 In IDLE, req with target out of range SHALL pulse err for 1 cycle, stay in IDLE, and leave cur unchanged.
REQ-021 req SHALL be ignored while busy=1, with no err pulse and the latched target unchanged.
REQ-022 CHECK SHALL last exactly 1 cycle: if cur==latched target, go to DONE; otherwise select a direction and go to PULSE.
REQ-023 With ALTEN=1, the direction SHALL always be up.
REQ-024 With ALTEN=0, the direction SHALL be up if target>cur and dn if target<cur.
REQ-025 In PULSE, the selected output (up or dn) SHALL be high for exactly PULSE_W cycles, and the other output SHALL stay low.
REQ-026 up and dn SHALL never be high in the same cycle.
REQ-027 On the last PULSE cycle, cur SHALL update at the clock edge where the output falls; cur is therefore new from the first GAP cycle.
REQ-028 Up update: if cur>=COUNTMAX, cur becomes COUNTMIN when ALTEN=1, or holds at COUNTMAX when ALTEN=0; otherwise cur becomes cur+1.
REQ-029 Dn update: if cur<=COUNTMIN, cur holds; otherwise cur becomes cur-1.
REQ-030 In GAP, up and dn SHALL be low for exactly GAP_W cycles, then the state returns to CHECK.
REQ-031 Each step SHALL take exactly 1+PULSE_W+GAP_W cycles.
REQ-032 A request needing N steps SHALL assert done exactly 1+N*(1+PULSE_W+GAP_W)+1 cycles after the req edge.
REQ-033 A zero-step request SHALL assert done 2 cycles after the req edge.
REQ-034 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE; a req arriving in DONE is ignored.
REQ-035 sync SHALL take effect only in IDLE; if sync and req are high in the same cycle, sync applies first and req is then evaluated against cur=SWDEF.
REQ-036 The pulse/gap timer SHALL be 16 bits wide and reload at each state entry; the cur arithmetic SHALL be 8-bit and never overflow past 255 or underflow past 0.

Reset
REQ-037 While rst_n=0: state=IDLE, cur=SWDEF, up=0, dn=0, busy=0, done=0, err=0, timer=0, latched target=SWDEF.
REQ-038 Reset asserted mid-PULSE SHALL drop up/dn within the same cycle (asynchronously), and the step in progress SHALL not count.
REQ-039 After rst_n deasserts, the first rising clk edge SHALL be able to accept req.

Verification
REQ-040 Defaults, cur=0, req with target=3 -> 3 up pulses, each 2 cycles high with a 3-cycle gap; cur steps 1,2,3; done 20 cycles after req; dn stays 0.
REQ-041 ALTEN=1, cur=4, req with target=1 -> 2 up pulses; cur goes 4->0->1; done after 1+2*6+1=14 cycles.
REQ-042 ALTEN=0, cur=4, req with target=2 -> 2 dn pulses; cur 3,2; up stays 0. Separately, cur=4 and a further up-step request saturates cur at 4.
REQ-043 req with target=7 (above COUNTMAX=4) -> err for exactly 1 cycle, no pulses, busy stays 0. A second req while busy -> ignored and the original target is still reached.
REQ-044 rst_n pulled low during the 2nd high cycle of a pulse -> up=0 immediately, cur=SWDEF, busy=0. Separately, sync in IDLE at cur=3 -> cur=0 with no pulse.
